aes_kexp_ctrl: RTL

AES_KEXP_CTRL -- requirements
Module: aes_kexp_ctrl

---
 rtl/aes_kexp_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/aes_kexp_ctrl.sv
// Round-robin controller sharing one AES key-expansion engine between two requesters.
// Optional key reuse (skip re-expansion of an already-expanded key) is built with AES_KEXP_REUSE_EN.
module aes_kexp_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int NREQ        = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] key_new_i,
  input  logic            kexp_rdy_i,
  output logic            kexp_en_o,
  output logic            key_sel_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] done_o,
  output logic [NREQ-1:0] err_o,
  output logic            busy_o
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          state, nstate;
  logic [CW-1:0]   cnt;
  logic            last, sel, win, hit;
  logic [NREQ-1:0] gnt;

  // With both requesting, the one not granted last wins; otherwise the lone requester.
  always_comb begin
    win = req_i[1];
    if (&req_i) win = ~last;
  end

`ifdef AES_KEXP_REUSE_EN
  logic [1:0] cvld;

  assign hit = cvld[win] & ~key_new_i[win] & (sel == win);

  // Granting one requester overwrites the shared table, so the other's entry goes stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              cvld <= '0;
    else if (state == S_IDLE && |req_i)    cvld[~win] <= 1'b0;
    else if (state == S_DONE)              cvld[sel] <= 1'b1;
    else if (state == S_ERR)               cvld[sel] <= 1'b0;
  end
`else
  logic unused_key_new;
  assign unused_key_new = ^key_new_i;
  assign hit            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (|req_i) nstate = hit ? S_DONE : S_START;
      S_START: nstate = S_WAIT;
      S_WAIT: begin
        if (kexp_rdy_i)                         nstate = S_DONE;
        else if (cnt == CW'(TIMEOUT_CYC - 1))   nstate = S_ERR;
      end
      S_DONE:  nstate = S_IDLE;
      S_ERR:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      last <= 1'b1;
      sel  <= 1'b0;
      gnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req_i) begin
          gnt  <= {win, ~win};
          last <= win;
          sel  <= win;
        end
        S_START: cnt <= '0;
        S_WAIT:  if (cnt != CW'(TIMEOUT_CYC)) cnt <= cnt + 1'b1;
        // DONE/ERR release the grant; key_sel keeps pointing at the table owner.
        default: gnt <= '0;
      endcase
    end
  end

  always_comb begin
    kexp_en_o = (state == S_START);
    busy_o    = (state != S_IDLE);
    done_o    = (state == S_DONE) ? gnt : '0;
    err_o     = (state == S_ERR)  ? gnt : '0;
    gnt_o     = gnt;
    key_sel_o = sel;
  end

endmodule
